// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory port arbiter and its watchdog.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    // Arbiter FSM encodings; IDLE sits between every pair of grants.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_t;

    // Instruction fetches always read a full word.
    localparam logic [3:0] MEM_BE_ALL = 4'hF;

endpackage

// File: rtl/mem_arb_wdog.sv
// Watchdog for an outstanding memory access: flags expiry after LIMIT busy cycles.
// Latency: expired rises combinationally in the LIMIT-th cycle with run=1 since the last clear.
// Backpressure: none; the counter stops at the limit until cleared.
module mem_arb_wdog
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int                CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt;

    // cnt holds the number of completed busy cycles, so the current cycle is cnt+1.
    assign expired = run && (cnt == LAST);

    // Count busy cycles; restart on each grant and hold once the limit is hit.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (run && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store; drives PC stall.
// Latency: registered grant, ack in the mem_ready cycle (min 1 cycle, one transfer per 2 cycles).
// Backpressure: requesters hold req until ack; stall holds the PC while any request is unacked.
// Optional: define MEM_ARB_TIMEOUT_EN to add a TIMEOUT_CYCLES watchdog that acks with err=1.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_RUN   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,

    output logic        err,
    output logic        stall,

    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int               RUN_W   = $clog2(MAX_DATA_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

    arb_state_t       state;
    logic [RUN_W-1:0] run_cnt;
    logic             starve;
    logic             busy;
    logic             timeout_hit;
    logic             fetch_done;
    logic             data_done;

    // Fetch has waited through a full run of data grants: it takes the next slot.
    assign starve = (run_cnt == RUN_MAX) && if_req;
    assign busy   = (state == FETCH) || (state == DATA);

`ifdef MEM_ARB_TIMEOUT_EN
    logic wdog_clear;

    // Idle is visited before every grant, so clearing there restarts the count per access.
    assign wdog_clear = (state == IDLE);

    mem_arb_wdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wdog_clear),
        .run     (busy),
        .expired (timeout_hit)
    );
`else
    // No watchdog: an access waits on mem_ready forever. The parameter is
    // referenced only so both builds present the same interface.
    assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    // A real mem_ready always wins over a coincident timeout.
    assign fetch_done = (state == FETCH) && (mem_ready || timeout_hit);
    assign data_done  = (state == DATA)  && (mem_ready || timeout_hit);

    // Grant FSM: data first unless fetch is starving; run_cnt tracks consecutive data grants.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            run_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_req && !starve) begin
                        state <= DATA;
                        if (!if_req) begin
                            run_cnt <= '0;
                        end else if (run_cnt != RUN_MAX) begin
                            run_cnt <= run_cnt + 1'b1;
                        end
                    end else if (if_req) begin
                        state   <= FETCH;
                        run_cnt <= '0;
                    end
                end
                FETCH: begin
                    if (fetch_done) begin
                        state <= IDLE;
                    end
                end
                DATA: begin
                    if (data_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory-side request fields follow the granted requester; zero when idle.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            FETCH: begin
                mem_req  = 1'b1;
                mem_be   = MEM_BE_ALL;
                mem_addr = if_addr;
            end
            DATA: begin
                mem_req   = 1'b1;
                mem_we    = d_we;
                mem_be    = d_be;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end
            default: ;
        endcase
    end

    assign if_ack   = fetch_done;
    assign d_ack    = data_done;
    assign err      = busy && timeout_hit && !mem_ready;

    // Read data only passes on a genuine completion; a timeout returns zero.
    assign if_rdata = ((state == FETCH) && mem_ready) ? mem_rdata : '0;
    assign d_rdata  = ((state == DATA)  && mem_ready) ? mem_rdata : '0;

    assign stall    = (if_req && !if_ack) || (d_req && !d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with an expected-grant scoreboard.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 1-2 units after it.
// Backpressure: the bench plays the memory, holding mem_ready off for a chosen number of cycles.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        err;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        is_fetch;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];

    mem_port_arbiter #(
        .MAX_DATA_RUN   (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .err       (err),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "bench time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_fetch(input logic [31:0] a);
        if_addr = a;
        if_req  = 1'b1;
        exp_q.push_back('{is_fetch: 1'b1, we: 1'b0, be: 4'hF, addr: a, wdata: 32'h0});
    endtask

    task automatic push_data(input logic w, input logic [3:0] be, input logic [31:0] a,
                             input logic [31:0] wd);
        d_we    = w;
        d_be    = be;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
        exp_q.push_back('{is_fetch: 1'b0, we: w, be: be, addr: a, wdata: wd});
    endtask

    // Act as memory for the next grant: check it against the scoreboard, wait lat
    // cycles, complete it with rd, check the ack, then retire the acked request.
    task automatic serve(input int lat, input logic [31:0] rd, output int waited);
        exp_t e;
        logic exp_stall;
        waited = 0;
        while (!mem_req && waited < 20) begin
            tick();
            waited++;
        end
        check("grant_seen", {31'h0, mem_req}, 32'h1);
        if (exp_q.size() == 0) begin
            check("scoreboard_nonempty", 32'h0, 32'h1);
            return;
        end
        e = exp_q.pop_front();
        check("grant_addr", mem_addr, e.addr);
        check("grant_we", {31'h0, mem_we}, {31'h0, e.we});
        check("grant_be", {28'h0, mem_be}, {28'h0, e.be});
        if (!e.is_fetch && e.we) check("grant_wdata", mem_wdata, e.wdata);
        for (int i = 0; i < lat; i++) begin
            check("wait_no_ack", {30'h0, if_ack, d_ack}, 32'h0);
            check("wait_stall", {31'h0, stall}, 32'h1);
            tick();
        end
        mem_ready = 1'b1;
        mem_rdata = rd;
        #1;
        exp_stall = e.is_fetch ? d_req : if_req;
        if (e.is_fetch) begin
            check("if_ack", {30'h0, if_ack, d_ack}, 32'h2);
            check("if_rdata", if_rdata, rd);
        end else begin
            check("d_ack", {30'h0, if_ack, d_ack}, 32'h1);
            check("d_rdata", d_rdata, rd);
        end
        check("ack_err", {31'h0, err}, 32'h0);
        check("ack_stall", {31'h0, stall}, {31'h0, exp_stall});
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        if (e.is_fetch) if_req = 1'b0;
        else            d_req  = 1'b0;
        #1;
        check("ack_one_cycle", {30'h0, if_ack, d_ack}, 32'h0);
    endtask

    initial begin
        int w;
        int n;
        int acks;
        int lows;

        reset     = 1'b1;
        if_req    = 1'b0;
        if_addr   = 32'h0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_be      = 4'h0;
        d_addr    = 32'h0;
        d_wdata   = 32'h0;
        mem_rdata = 32'h0;
        mem_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_mem_be", {28'h0, mem_be}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_acks_err", {29'h0, if_ack, d_ack, err}, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_stall", {31'h0, stall}, 32'h0);
        reset = 1'b0;
        tick();

        // Fetch only, memory answers 2 cycles after mem_req
        push_fetch(32'h100);
        #1;
        check("fetch_stall_pending", {31'h0, stall}, 32'h1);
        serve(2, 32'h0050_0093, w);
        check("fetch_grant_latency", w, 1);
        tick();

        // Contention: store wins, fetch granted right after the IDLE cycle
        push_data(1'b1, 4'b0011, 32'h2000, 32'hDEAD_BEEF);
        push_fetch(32'h104);
        serve(1, 32'h0, w);
        check("cont_data_latency", w, 1);
        serve(0, 32'h0011_2233, w);
        check("cont_fetch_latency", w, 1);
        tick();

        // Starvation: data held with fetch pending -> 4 data, 1 fetch, data resumes
        if_addr = 32'h200;
        if_req  = 1'b1;
        push_data(1'b0, 4'hF, 32'h3000, 32'h0);
        for (int i = 0; i < 4; i++) begin
            serve(0, 32'hA000_0000 + i, w);
            if (i == 3) begin
                exp_q.push_back('{is_fetch: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h200, wdata: 32'h0});
            end
            push_data(1'b1, 4'hF, 32'h3004 + 4 * i, 32'h5500_0000 + i);
        end
        serve(0, 32'h0000_0013, w);
        serve(0, 32'h0, w);
        check("starve_sb_drained", exp_q.size(), 0);
        tick();

        // Stray mem_ready in IDLE is ignored, then a 1-cycle fetch still works
        mem_ready = 1'b1;
        mem_rdata = 32'h5555_5555;
        #1;
        check("stray_no_ack", {30'h0, if_ack, d_ack}, 32'h0);
        check("stray_rdata", if_rdata | d_rdata, 32'h0);
        tick();
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        check("stray_stays_idle", {31'h0, mem_req}, 32'h0);
        push_fetch(32'h300);
        serve(0, 32'h0000_0513, w);
        check("min_latency_grant", w, 1);
        tick();

        // Reset while DATA waits on mem_ready
        d_we    = 1'b1;
        d_be    = 4'b1100;
        d_addr  = 32'h4000;
        d_wdata = 32'h1234_5678;
        d_req   = 1'b1;
        n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        check("rstmid_granted", {31'h0, mem_req}, 32'h1);
        tick();
        reset = 1'b1;
        #1;
        check("rstmid_no_ack_before", {30'h0, if_ack, d_ack}, 32'h0);
        tick();
        check("rstmid_mem_req", {31'h0, mem_req}, 32'h0);
        check("rstmid_no_ack", {30'h0, if_ack, d_ack}, 32'h0);
        check("rstmid_mem_fields", {mem_we, mem_be, mem_addr[26:0]}, 32'h0);
        check("rstmid_mem_wdata", mem_wdata, 32'h0);
        check("rstmid_d_rdata", d_rdata, 32'h0);
        d_req = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("rstmid_idle_after", {31'h0, mem_req}, 32'h0);

        // Memory never answers
        mem_rdata = 32'hFFFF_FFFF;
        d_we      = 1'b0;
        d_be      = 4'hF;
        d_addr    = 32'h5000;
        d_req     = 1'b1;
        n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        check("hang_granted", {31'h0, mem_req}, 32'h1);
`ifdef MEM_ARB_TIMEOUT_EN
        n = 1;
        while (!d_ack && n < 50) begin
            tick();
            n++;
        end
        check("timeout_cycle", n, 8);
        check("timeout_err", {31'h0, err}, 32'h1);
        check("timeout_rdata", d_rdata, 32'h0);
        check("timeout_if_ack", {31'h0, if_ack}, 32'h0);
        tick();
        d_req = 1'b0;
        #1;
        check("timeout_pulse", {30'h0, d_ack, err}, 32'h0);
`else
        acks = 0;
        lows = 0;
        for (int i = 0; i < 120; i++) begin
            if (d_ack || if_ack || err) acks++;
            if (!stall) lows++;
            tick();
        end
        check("hang_no_ack", acks, 0);
        check("hang_stall_high", lows, 0);
        check("hang_still_req", {31'h0, mem_req}, 32'h1);
        reset = 1'b1;
        d_req = 1'b0;
        tick();
        reset = 1'b0;
`endif
        mem_rdata = 32'h0;
        tick();
        check("end_idle", {31'h0, mem_req}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
